// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake, Booth multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to compile in the divider (DIV/DFIX states and the dz flag).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [4:0] OP_DIV = 5'b01111;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] zhi_q, zhi_d;
  logic [WIDTH-1:0] zlo_q, zlo_d;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] ror_res, rol_res;
  logic [WIDTH:0]   booth_sum;

`ifdef SEQ_ALU_DIV_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d, dz_set;
  logic [WIDTH-1:0] ra_abs, rb_abs;
  logic [WIDTH:0]   div_shift, div_trial;

  assign ra_abs    = Ra[WIDTH-1] ? ('0 - Ra) : Ra;
  assign rb_abs    = Rb[WIDTH-1] ? ('0 - Rb) : Rb;
  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign div_trial = div_shift - opnd_q;
`endif

  // Rotates shift a doubled copy of Ra so an amount of zero needs no special case.
  assign amt     = Rb[SHW-1:0];
  assign ror_res = WIDTH'({Ra, Ra} >> amt);
  assign rol_res = WIDTH'(({Ra, Ra} << amt) >> WIDTH);

  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + opnd_q;
      2'b10:   booth_sum = acc_q - opnd_q;
      default: booth_sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    done_d  = 1'b0;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
`ifdef SEQ_ALU_DIV_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_set  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b1;
          zhi_d  = '0;
          case (opcode)
            OP_ADD: zlo_d = Ra + Rb;
            OP_SUB: zlo_d = Ra - Rb;
            OP_SHR: zlo_d = Ra >> amt;
            OP_SHL: zlo_d = Ra << amt;
            OP_ROR: zlo_d = ror_res;
            OP_ROL: zlo_d = rol_res;
            OP_AND: zlo_d = Ra & Rb;
            OP_OR:  zlo_d = Ra | Rb;
            OP_NEG: zlo_d = '0 - Ra;
            OP_NOT: zlo_d = ~Ra;
            OP_MUL: begin
              done_d  = 1'b0;
              zhi_d   = zhi_q;
              state_d = MUL;
              count_d = CW'(WIDTH);
              acc_d   = '0;
              opnd_d  = {Ra[WIDTH-1], Ra};
              q_d     = Rb;
              qm1_d   = 1'b0;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIV: begin
              if (Rb == '0) begin
                zlo_d  = '1;
                zhi_d  = Ra;
                dz_set = 1'b1;
              end else begin
                done_d  = 1'b0;
                zhi_d   = zhi_q;
                state_d = DIV;
                count_d = CW'(WIDTH);
                acc_d   = '0;
                opnd_d  = {1'b0, rb_abs};
                q_d     = ra_abs;
                q_neg_d = Ra[WIDTH-1] ^ Rb[WIDTH-1];
                r_neg_d = Ra[WIDTH-1];
              end
            end
`endif
            default: zlo_d = '0;
          endcase
        end
      end
      MUL: begin
        // Arithmetic shift right of {acc, q, q-1} after the Booth add/subtract.
        {acc_d, q_d, qm1_d} = {booth_sum[WIDTH], booth_sum, q_q};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          zhi_d   = acc_d[WIDTH-1:0];
          zlo_d   = q_d;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      DIV: begin
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = DFIX;
      end
      DFIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        zlo_d   = q_neg_q ? ('0 - q_q) : q_q;
        zhi_d   = r_neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef SEQ_ALU_DIV_EN
    dz_d = done_d ? dz_set : dz_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      done_q  <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      done_q  <= done_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
`ifdef SEQ_ALU_DIV_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ZHI  = zhi_q;
  assign ZLO  = zlo_q;
`ifdef SEQ_ALU_DIV_EN
  assign dz   = dz_q;
`else
  assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=32); divide expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] Ra, Rb;
  logic         busy, done, dz;
  logic [W-1:0] ZHI, ZLO;

  int tests_run = 0;
  int tests_failed = 0;
  int k;
  int done_count;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .Ra(Ra), .Rb(Rb), .busy(busy), .done(done), .ZHI(ZHI), .ZLO(ZLO), .dz(dz)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulses start for one cycle; returns half a cycle after the accepting edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start  = 1'b1;
    opcode = op;
    Ra     = a;
    Rb     = b;
    @(negedge clock);
    start  = 1'b0;
  endtask

  // k counts edges after the accepting edge until done is seen.
  task automatic waitDone(input int k0, output int kout);
    kout = k0;
    while (done !== 1'b1 && kout < 200) begin
      @(negedge clock);
      kout++;
    end
  endtask

  task automatic runOp(input string tag, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dz, input int exp_k);
    int kk;
    applyStimulus(op, a, b);
    waitDone(0, kk);
    checkOutput({tag, ".lat"}, 64'(kk), 64'(exp_k));
    checkOutput({tag, ".zhi"}, 64'(ZHI), 64'(exp_hi));
    checkOutput({tag, ".zlo"}, 64'(ZLO), 64'(exp_lo));
    checkOutput({tag, ".dz"}, 64'(dz), 64'(exp_dz));
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; opcode = '0; Ra = '0; Rb = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst.busy", 64'(busy), 64'd0);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.zhi", 64'(ZHI), 64'd0);
    checkOutput("rst.zlo", 64'(ZLO), 64'd0);
    checkOutput("rst.dz", 64'(dz), 64'd0);
    clear = 1'b0;

    runOp("sub", 5'b00100, 32'd10, 32'd3, 32'h0, 32'h7, 1'b0, 0);
    runOp("add", 5'b00011, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 0);
    @(negedge clock);
    checkOutput("add.pulse", 64'(done), 64'd0);
    checkOutput("add.busy2", 64'(busy), 64'd0);
    runOp("ror", 5'b00111, 32'h80000001, 32'd36, 32'h0, 32'h18000000, 1'b0, 0);
    runOp("rol", 5'b01000, 32'h80000001, 32'd1, 32'h0, 32'h00000003, 1'b0, 0);
    runOp("ror0", 5'b00111, 32'hDEADBEEF, 32'd32, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    runOp("shr", 5'b00101, 32'hF0000000, 32'd4, 32'h0, 32'h0F000000, 1'b0, 0);
    runOp("shl", 5'b00110, 32'h00000001, 32'd31, 32'h0, 32'h80000000, 1'b0, 0);
    runOp("and", 5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0, 0);
    runOp("or", 5'b01010, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'hFFFFF0F0, 1'b0, 0);
    runOp("neg", 5'b10000, 32'h00000001, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0);
    runOp("not", 5'b10001, 32'h0000FFFF, 32'h0, 32'h0, 32'hFFFF0000, 1'b0, 0);

    // Multiply with a start pulsed while busy, which must be ignored.
    applyStimulus(5'b01110, 32'hFFFFFFFD, 32'd7);
    checkOutput("mul.busy", 64'(busy), 64'd1);
    @(negedge clock);
    start = 1'b1; opcode = 5'b00011; Ra = 32'd1; Rb = 32'd1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("mul.nodone", 64'(done), 64'd0);
    waitDone(2, k);
    checkOutput("mul.lat", 64'(k), 64'd32);
    checkOutput("mul.zhi", 64'(ZHI), 64'hFFFFFFFF);
    checkOutput("mul.zlo", 64'(ZLO), 64'hFFFFFFEB);
    checkOutput("mul.busy0", 64'(busy), 64'd0);
    @(negedge clock);
    checkOutput("mul.pulse", 64'(done), 64'd0);

    runOp("ill", 5'b11111, 32'h12345678, 32'h9, 32'h0, 32'h0, 1'b0, 0);
    runOp("mulmin", 5'b01110, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 32);
    runOp("mulm1", 5'b01110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 32);

`ifdef SEQ_ALU_DIV_EN
    runOp("div", 5'b01111, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    runOp("divpos", 5'b01111, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 33);
    runOp("divz", 5'b01111, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 0);
    runOp("divwrap", 5'b01111, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
`else
    runOp("div", 5'b01111, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 0);
`endif

    // Abort a multiply part way through; no done may follow.
    runOp("pre", 5'b01110, 32'h00001000, 32'h00100001, 32'h1, 32'h00001000, 1'b0, 32);
    applyStimulus(5'b01110, 32'h12345678, 32'h100);
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkOutput("clr.busy", 64'(busy), 64'd0);
    checkOutput("clr.done", 64'(done), 64'd0);
    checkOutput("clr.zhi", 64'(ZHI), 64'd0);
    checkOutput("clr.zlo", 64'(ZLO), 64'd0);
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) done_count++;
    end
    checkOutput("clr.nodone", 64'(done_count), 64'd0);
    runOp("add2", 5'b00011, 32'd2, 32'd3, 32'h0, 32'h5, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
